// File: rtl/seed128_dec_core_pkg.sv
// Shared types and constants for the SEED-128 decryption core: FSM state
// encoding, round count, word width, G-function byte masks and the two
// byte S-boxes that the SS0..SS3 lookups are built from.
package seed128_dec_core_pkg;

  localparam int NUM_ROUNDS_DEFAULT = 16;
  localparam int WORD_W             = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Byte-lane masks of the G function (m0..m3).
  localparam logic [7:0] M0 = 8'hfc;
  localparam logic [7:0] M1 = 8'hf3;
  localparam logic [7:0] M2 = 8'hcf;
  localparam logic [7:0] M3 = 8'h3f;

  localparam logic [7:0] S1_TABLE [256] = '{
    8'd169, 8'd133, 8'd214, 8'd211, 8'd84,  8'd29,  8'd172, 8'd37,  8'd93,  8'd67,  8'd24,  8'd30,  8'd81,  8'd252, 8'd202, 8'd99,
    8'd40,  8'd68,  8'd32,  8'd157, 8'd224, 8'd226, 8'd200, 8'd23,  8'd165, 8'd143, 8'd3,   8'd123, 8'd187, 8'd19,  8'd210, 8'd238,
    8'd112, 8'd140, 8'd63,  8'd168, 8'd50,  8'd221, 8'd246, 8'd116, 8'd236, 8'd149, 8'd11,  8'd87,  8'd92,  8'd91,  8'd189, 8'd1,
    8'd36,  8'd28,  8'd115, 8'd152, 8'd16,  8'd204, 8'd242, 8'd217, 8'd44,  8'd231, 8'd114, 8'd131, 8'd155, 8'd209, 8'd134, 8'd201,
    8'd96,  8'd80,  8'd163, 8'd235, 8'd13,  8'd182, 8'd158, 8'd79,  8'd183, 8'd90,  8'd198, 8'd120, 8'd166, 8'd18,  8'd175, 8'd213,
    8'd97,  8'd195, 8'd180, 8'd65,  8'd82,  8'd125, 8'd141, 8'd8,   8'd31,  8'd153, 8'd0,   8'd25,  8'd4,   8'd83,  8'd247, 8'd225,
    8'd253, 8'd118, 8'd47,  8'd39,  8'd176, 8'd139, 8'd14,  8'd171, 8'd162, 8'd110, 8'd147, 8'd77,  8'd105, 8'd124, 8'd9,   8'd10,
    8'd191, 8'd239, 8'd243, 8'd197, 8'd135, 8'd20,  8'd254, 8'd100, 8'd222, 8'd46,  8'd75,  8'd26,  8'd6,   8'd33,  8'd107, 8'd102,
    8'd2,   8'd245, 8'd146, 8'd138, 8'd12,  8'd179, 8'd126, 8'd208, 8'd122, 8'd71,  8'd150, 8'd229, 8'd38,  8'd128, 8'd173, 8'd223,
    8'd161, 8'd48,  8'd55,  8'd174, 8'd54,  8'd21,  8'd34,  8'd56,  8'd244, 8'd167, 8'd69,  8'd76,  8'd129, 8'd233, 8'd132, 8'd151,
    8'd53,  8'd203, 8'd206, 8'd60,  8'd113, 8'd17,  8'd199, 8'd137, 8'd117, 8'd251, 8'd218, 8'd248, 8'd148, 8'd89,  8'd130, 8'd196,
    8'd255, 8'd73,  8'd57,  8'd103, 8'd192, 8'd207, 8'd215, 8'd184, 8'd15,  8'd142, 8'd66,  8'd35,  8'd145, 8'd108, 8'd219, 8'd164,
    8'd52,  8'd241, 8'd72,  8'd194, 8'd111, 8'd61,  8'd45,  8'd64,  8'd190, 8'd62,  8'd188, 8'd193, 8'd170, 8'd186, 8'd78,  8'd85,
    8'd59,  8'd220, 8'd104, 8'd127, 8'd156, 8'd216, 8'd74,  8'd86,  8'd119, 8'd160, 8'd237, 8'd70,  8'd181, 8'd43,  8'd101, 8'd250,
    8'd227, 8'd185, 8'd177, 8'd159, 8'd94,  8'd249, 8'd230, 8'd178, 8'd49,  8'd234, 8'd109, 8'd95,  8'd228, 8'd240, 8'd205, 8'd136,
    8'd22,  8'd58,  8'd88,  8'd212, 8'd98,  8'd41,  8'd7,   8'd51,  8'd232, 8'd27,  8'd5,   8'd121, 8'd144, 8'd106, 8'd42,  8'd154
  };

  localparam logic [7:0] S2_TABLE [256] = '{
    8'd56,  8'd232, 8'd45,  8'd166, 8'd207, 8'd222, 8'd179, 8'd184, 8'd175, 8'd96,  8'd85,  8'd199, 8'd68,  8'd111, 8'd107, 8'd91,
    8'd195, 8'd98,  8'd51,  8'd181, 8'd41,  8'd160, 8'd226, 8'd167, 8'd211, 8'd145, 8'd17,  8'd6,   8'd28,  8'd188, 8'd54,  8'd75,
    8'd239, 8'd136, 8'd108, 8'd168, 8'd23,  8'd196, 8'd22,  8'd244, 8'd194, 8'd69,  8'd225, 8'd214, 8'd63,  8'd61,  8'd142, 8'd152,
    8'd40,  8'd78,  8'd246, 8'd62,  8'd165, 8'd249, 8'd13,  8'd223, 8'd216, 8'd43,  8'd102, 8'd122, 8'd39,  8'd47,  8'd241, 8'd114,
    8'd66,  8'd212, 8'd65,  8'd192, 8'd115, 8'd103, 8'd172, 8'd139, 8'd247, 8'd173, 8'd128, 8'd31,  8'd202, 8'd44,  8'd170, 8'd52,
    8'd210, 8'd11,  8'd238, 8'd233, 8'd93,  8'd148, 8'd24,  8'd248, 8'd87,  8'd174, 8'd8,   8'd197, 8'd19,  8'd205, 8'd134, 8'd185,
    8'd255, 8'd125, 8'd193, 8'd49,  8'd245, 8'd138, 8'd106, 8'd177, 8'd209, 8'd32,  8'd215, 8'd2,   8'd34,  8'd4,   8'd104, 8'd113,
    8'd7,   8'd219, 8'd157, 8'd153, 8'd97,  8'd190, 8'd230, 8'd89,  8'd221, 8'd81,  8'd144, 8'd220, 8'd154, 8'd163, 8'd171, 8'd208,
    8'd129, 8'd15,  8'd71,  8'd26,  8'd227, 8'd236, 8'd141, 8'd191, 8'd150, 8'd123, 8'd92,  8'd162, 8'd161, 8'd99,  8'd35,  8'd77,
    8'd200, 8'd158, 8'd156, 8'd58,  8'd12,  8'd46,  8'd186, 8'd110, 8'd159, 8'd90,  8'd242, 8'd146, 8'd243, 8'd73,  8'd120, 8'd204,
    8'd21,  8'd251, 8'd112, 8'd117, 8'd127, 8'd53,  8'd16,  8'd3,   8'd100, 8'd109, 8'd198, 8'd116, 8'd213, 8'd180, 8'd234, 8'd9,
    8'd118, 8'd25,  8'd254, 8'd64,  8'd18,  8'd224, 8'd189, 8'd5,   8'd250, 8'd1,   8'd240, 8'd42,  8'd94,  8'd169, 8'd86,  8'd67,
    8'd133, 8'd20,  8'd137, 8'd155, 8'd176, 8'd229, 8'd72,  8'd121, 8'd151, 8'd252, 8'd30,  8'd130, 8'd33,  8'd140, 8'd27,  8'd95,
    8'd119, 8'd84,  8'd178, 8'd29,  8'd37,  8'd79,  8'd0,   8'd70,  8'd237, 8'd88,  8'd82,  8'd235, 8'd126, 8'd218, 8'd201, 8'd253,
    8'd48,  8'd149, 8'd101, 8'd60,  8'd182, 8'd228, 8'd187, 8'd124, 8'd14,  8'd80,  8'd57,  8'd38,  8'd50,  8'd132, 8'd105, 8'd147,
    8'd55,  8'd231, 8'd36,  8'd164, 8'd203, 8'd83,  8'd10,  8'd135, 8'd217, 8'd76,  8'd131, 8'd143, 8'd206, 8'd59,  8'd74,  8'd183
  };

endpackage

// File: rtl/seed128_dec_core_if.sv
// Streaming bus of the SEED-128 decryption core: ciphertext in, round-key
// lookup, plaintext out. The master side feeds ciphertext and keys and
// consumes plaintext; the slave side is the core.
interface seed128_dec_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [63:0]  round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, round_key, out_ready,
    input  in_ready, key_idx, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, round_key, out_ready,
    output in_ready, key_idx, out_valid, out_data
  );
endinterface

// File: rtl/seed_f.sv
// SEED round function F(R, K): key mix followed by three chained G stages
// with mod-2^32 additions between them. Purely combinational.
module seed_f
  import seed128_dec_core_pkg::*;
(
  input  logic [63:0] r,
  input  logic [63:0] k,
  output logic [63:0] f
);

  word_t t0_a, t1_a, t1_b, t0_b, t1_c;
  word_t g1_in, g2_in, g3_in;

  assign t0_a  = r[63:32] ^ k[63:32];
  assign t1_a  = r[31:0]  ^ k[31:0];
  assign g1_in = t0_a ^ t1_a;
  assign g2_in = t0_a + t1_b;
  assign g3_in = t1_b + t0_b;

  seed_g u_g1 (.x(g1_in), .y(t1_b));
  seed_g u_g2 (.x(g2_in), .y(t0_b));
  seed_g u_g3 (.x(g3_in), .y(t1_c));

  assign f = {t0_b + t1_c, t1_c};

endmodule

// File: rtl/seed_g.sv
// SEED G function: XOR of the four SS lookups, byte 0 (LSB) through byte 3.
module seed_g
  import seed128_dec_core_pkg::*;
(
  input  word_t x,
  output word_t y
);

  word_t ss0, ss1, ss2, ss3;

  seed_ss #(.SEL(0)) u_ss0 (.x(x[7:0]),   .y(ss0));
  seed_ss #(.SEL(1)) u_ss1 (.x(x[15:8]),  .y(ss1));
  seed_ss #(.SEL(2)) u_ss2 (.x(x[23:16]), .y(ss2));
  seed_ss #(.SEL(3)) u_ss3 (.x(x[31:24]), .y(ss3));

  assign y = ss0 ^ ss1 ^ ss2 ^ ss3;

endmodule

// File: rtl/seed_ss.sv
// One SEED SS lookup (SS0..SS3 selected by SEL): a byte S-box result spread
// across four byte lanes, each lane under a different G mask.
module seed_ss
  import seed128_dec_core_pkg::*;
#(
  parameter int SEL = 0
) (
  input  logic [7:0] x,
  output word_t      y
);

  logic [7:0] s;

  // SS0/SS2 use S1, SS1/SS3 use S2; the mask order rotates by one lane per table.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    s = (SEL % 2 == 0) ? S1_TABLE[x] : S2_TABLE[x];
    y = '0;
    case (SEL)
      0:       y = {s & M3, s & M2, s & M1, s & M0};
      1:       y = {s & M0, s & M3, s & M2, s & M1};
      2:       y = {s & M1, s & M0, s & M3, s & M2};
      default: y = {s & M2, s & M1, s & M0, s & M3};
    endcase
  end

endmodule

// File: rtl/seed128_dec_core.sv
// SEED-128 block decryption core. One Feistel round per cycle with round keys
// fetched from an external combinational key store, K16 first. Block flow:
// IDLE (accept) -> 16 x ROUND -> DONE (hold until taken) -> IDLE.
module seed128_dec_core
  import seed128_dec_core_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_Data,
  output logic [3:0]   o_KeyIdx,
  input  logic [63:0]  i_RoundKey,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [127:0] o_Data
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] l_q, l_d;
  logic [63:0] r_q, r_d;
  logic        valid_q, valid_d;
  logic [63:0] f_out;

  seed_f u_f (
    .r (r_q),
    .k (i_RoundKey),
    .f (f_out)
  );

  // Next-state logic: load on accept, one Feistel round per ROUND cycle,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Valid) begin
          l_d     = i_Data[127:64];
          r_d     = i_Data[63:0];
          cnt_d   = LAST_IDX;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        l_d = r_q;
        r_d = l_q ^ f_out;
        if (cnt_q == 4'd0) begin
          // Counter parks at 0 so the key index reads 0 outside ROUND.
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (i_Ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    // NOTE: nonblocking assignments so every flop samples pre-edge values, independent of statement order.
    if (i_Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      valid_q <= valid_d;
    end
  end

  // The last round leaves the halves swapped; presenting {R, L} undoes it.
  assign o_Data   = {r_q, l_q};
  assign o_Valid  = valid_q;
  assign o_KeyIdx = cnt_q;
  assign o_Ready  = (state_q == ST_IDLE) && !i_Rst;

endmodule

// File: tb/tb_seed128_dec_core.sv
// Directed bench for seed128_dec_core: reset values, KISA known-answer vectors,
// key-index sequence and latency, backpressure, back-to-back blocks, mid-block
// reset and an encrypt/decrypt round trip with a bench-side SEED model.
module tb_seed128_dec_core;
  import seed128_dec_core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] rk_tab [16];

  seed128_dec_core_if bus ();

  always #5 clk = ~clk;

  assign bus.round_key = rk_tab[bus.key_idx];

  seed128_dec_core #(.NUM_ROUNDS(16)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Valid    (bus.in_valid),
    .o_Ready    (bus.in_ready),
    .i_Data     (bus.in_data),
    .o_KeyIdx   (bus.key_idx),
    .i_RoundKey (bus.round_key),
    .o_Valid    (bus.out_valid),
    .i_Ready    (bus.out_ready),
    .o_Data     (bus.out_data)
  );

  localparam logic [127:0] KISA1_CT = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
  localparam logic [127:0] KISA1_PT = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KISA2_KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KISA2_CT = 128'hC11F22F20140505084483597E4370F43;
  localparam logic [127:0] KISA2_PT = 128'h0;

  // SEED G written in byte-lane form: Z_j = XOR of masked S-box outputs.
  function automatic logic [31:0] g_fn(input logic [31:0] x);
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    y0 = S1_TABLE[x[7:0]];
    y1 = S2_TABLE[x[15:8]];
    y2 = S1_TABLE[x[23:16]];
    y3 = S2_TABLE[x[31:24]];
    z0 = (y0 & 8'hfc) ^ (y1 & 8'hf3) ^ (y2 & 8'hcf) ^ (y3 & 8'h3f);
    z1 = (y0 & 8'hf3) ^ (y1 & 8'hcf) ^ (y2 & 8'h3f) ^ (y3 & 8'hfc);
    z2 = (y0 & 8'hcf) ^ (y1 & 8'h3f) ^ (y2 & 8'hfc) ^ (y3 & 8'hf3);
    z3 = (y0 & 8'h3f) ^ (y1 & 8'hfc) ^ (y2 & 8'hf3) ^ (y3 & 8'hcf);
    return {z3, z2, z1, z0};
  endfunction

  function automatic logic [63:0] f_fn(input logic [63:0] r, input logic [63:0] k);
    logic [31:0] t0, t1;
    t0 = r[63:32] ^ k[63:32];
    t1 = r[31:0] ^ k[31:0];
    t1 = g_fn(t0 ^ t1);
    t0 = g_fn(t0 + t1);
    t1 = g_fn(t1 + t0);
    t0 = t0 + t1;
    return {t0, t1};
  endfunction

  // SEED key schedule: KC_i = golden ratio rotated left by i; AB rotates right
  // after even rounds, CD rotates left after odd rounds.
  task automatic load_key(input logic [127:0] key);
    logic [31:0] a, b, c, d, kc, gold;
    logic [63:0] pair;
    gold = 32'h9e3779b9;
    a = key[127:96]; b = key[95:64]; c = key[63:32]; d = key[31:0];
    for (int i = 0; i < 16; i++) begin
      kc = (i == 0) ? gold : ((gold << i) | (gold >> (32 - i)));
      rk_tab[i] = {g_fn(a + c - kc), g_fn(b - d + kc)};
      if (i % 2 == 0) begin
        pair = {a, b};
        pair = {pair[7:0], pair[63:8]};
        a = pair[63:32]; b = pair[31:0];
      end else begin
        pair = {c, d};
        pair = {pair[55:0], pair[63:56]};
        c = pair[63:32]; d = pair[31:0];
      end
    end
  endtask

  function automatic logic [127:0] enc_fn(input logic [127:0] p);
    logic [63:0] l, r, t;
    l = p[127:64];
    r = p[63:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_fn(r, rk_tab[i]);
      l = t;
    end
    return {r, l};
  endfunction

  // Offer one block at the current falling edge; returns one edge after acceptance.
  task automatic send(input logic [127:0] ct);
    bus.in_data  = ct;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n, output bit hit);
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = bus.out_valid;
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.key_idx, bus.out_data} !== 134'h0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b idx=%0d data=%h want all 0",
               bus.in_ready, bus.out_valid, bus.key_idx, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_kisa_keyidx();
    int idx_errs;
    load_key(128'h0);
    send(KISA1_CT);
    idx_errs = 0;
    for (int k = 0; k < 16; k++) begin
      if (k != 0) @(negedge clk);
      if (bus.key_idx !== 4'(15 - k) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        idx_errs++;
        $display("FAIL keyidx_round%0d: idx=%0d valid=%b ready=%b want idx=%0d valid=0 ready=0",
                 k, bus.key_idx, bus.out_valid, bus.in_ready, 15 - k);
      end
    end
    total++;
    if (idx_errs != 0) bad++;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL kisa1_latency: valid=%b want 1 in cycle 17 counting the accept cycle", bus.out_valid);
    end
    total++;
    if (bus.out_data !== KISA1_PT) begin
      bad++;
      $display("FAIL kisa1_data: got %h want %h", bus.out_data, KISA1_PT);
    end
    total++;
    if (bus.key_idx !== 4'd0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL done_idx_ready: idx=%0d ready=%b want 0 0", bus.key_idx, bus.in_ready);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.key_idx !== 4'd0) begin
      bad++;
      $display("FAIL after_transfer: valid=%b ready=%b idx=%0d want 0 1 0",
               bus.out_valid, bus.in_ready, bus.key_idx);
    end
  endtask

  task automatic test_backpressure();
    int  n;
    bit  hit;
    load_key(128'h0);
    bus.out_ready = 1'b0;
    send(KISA1_CT);
    wait_valid(40, n, hit);
    total++;
    if (!hit || n != 16) begin
      bad++;
      $display("FAIL bp_latency: hit=%b edges=%0d want hit=1 edges=16", hit, n);
    end
    for (int j = 0; j < 5; j++) begin
      bus.in_valid = (j % 2 == 0);
      bus.in_data  = {4{32'hdeadbeef}};
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== KISA1_PT || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b want 1 %h 0",
                 j, bus.out_valid, bus.out_data, bus.in_ready, KISA1_PT);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.key_idx !== 4'd0) begin
      bad++;
      $display("FAIL bp_no_ghost_block: ready=%b idx=%0d want 1 0", bus.in_ready, bus.key_idx);
    end
  endtask

  task automatic test_back_to_back();
    int  n;
    bit  hit;
    logic [127:0] pt2, ct2;
    load_key(128'h0);
    pt2 = 128'h0123456789ABCDEFFEDCBA9876543210;
    ct2 = enc_fn(pt2);
    bus.in_data  = KISA1_CT;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_data = ct2;
    wait_valid(40, n, hit);
    total++;
    if (!hit || bus.out_data !== KISA1_PT) begin
      bad++;
      $display("FAIL b2b_first: hit=%b data=%h want %h", hit, bus.out_data, KISA1_PT);
    end
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle_gap: ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0 || bus.key_idx !== 4'd15) begin
      bad++;
      $display("FAIL b2b_second_accept: ready=%b idx=%0d want 0 15", bus.in_ready, bus.key_idx);
    end
    wait_valid(40, n, hit);
    total++;
    if (!hit || n != 16 || bus.out_data !== pt2) begin
      bad++;
      $display("FAIL b2b_second: hit=%b edges=%0d data=%h want 1 16 %h", hit, n, bus.out_data, pt2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_round();
    int  n;
    bit  hit;
    bit  seen;
    load_key(128'h0);
    send(KISA1_CT);
    n = 0;
    while (bus.key_idx !== 4'd8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.key_idx !== 4'd8 || n != 7) begin
      bad++;
      $display("FAIL mid_reach_idx8: idx=%0d edges=%0d want 8 7", bus.key_idx, n);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.key_idx, bus.out_data} !== 134'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: ready=%b valid=%b idx=%0d data=%h want all 0",
               bus.in_ready, bus.out_valid, bus.key_idx, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_no_valid: seen_valid=%b ready=%b want 0 1", seen, bus.in_ready);
    end
    load_key(KISA2_KEY);
    send(KISA2_CT);
    wait_valid(40, n, hit);
    total++;
    if (!hit || n != 16 || bus.out_data !== KISA2_PT) begin
      bad++;
      $display("FAIL mid_fresh_block: hit=%b edges=%0d data=%h want 1 16 %h",
               hit, n, bus.out_data, KISA2_PT);
    end
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    int  n;
    bit  hit;
    logic [127:0] key, pt, ct;
    for (int t = 0; t < 1000; t++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_key(key);
      ct = enc_fn(pt);
      send(ct);
      wait_valid(40, n, hit);
      total++;
      if (!hit || bus.out_data !== pt) begin
        bad++;
        $display("FAIL round_trip%0d: hit=%b key=%h got %h want %h", t, hit, key, bus.out_data, pt);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) rk_tab[i] = '0;
    test_reset();
    test_kisa_keyidx();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_round();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
